// File: rtl/alu_seq_if.sv
// alu_seq_if: start/IR inputs and datapath control strobes
// exchanged between the sequencer (master) and the datapath (slave).
interface alu_seq_if #(
  parameter int NUM_REGS = 16
);
  logic                start;
  logic [31:0]         ir;
  logic                busy;
  logic                done;
  logic                illegal;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic                pc_out;
  logic                pc_in;
  logic                inc_pc;
  logic                mar_in;
  logic                mdr_in;
  logic                mdr_out;
  logic                read;
  logic                ir_in;
  logic                y_in;
  logic                z_in;
  logic                zlow_out;
  logic                zhigh_out;
  logic                hi_in;
  logic                lo_in;
  logic [12:0]         alu_sel;

  modport master (
    input  start, ir,
    output busy, done, illegal, reg_in, reg_out,
    output pc_out, pc_in, inc_pc, mar_in, mdr_in,
    output mdr_out, read, ir_in, y_in, z_in,
    output zlow_out, zhigh_out, hi_in, lo_in, alu_sel
  );

  modport slave (
    output start, ir,
    input  busy, done, illegal, reg_in, reg_out,
    input  pc_out, pc_in, inc_pc, mar_in, mdr_in,
    input  mdr_out, read, ir_in, y_in, z_in,
    input  zlow_out, zhigh_out, hi_in, lo_in, alu_sel
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: T-state control unit for register-register ALU ops.
// `SEQ_SINGLE_STEP_EN adds step_en: non-IDLE/DONE states advance only when set.
module alu_instr_sequencer #(
  parameter int NUM_REGS         = 16,
  parameter int REG_SEL_W        = 4,
  parameter int MEM_WAIT         = 0,
  parameter int R0_WRITE_INHIBIT = 0
) (
  input logic       clk,
  input logic       reset,
`ifdef SEQ_SINGLE_STEP_EN
  input logic       step_en,
`endif
  alu_seq_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_BIN, C_TWO, C_UN, C_ILL
  } cls_t;

  typedef struct packed {
    logic                busy;
    logic                done;
    logic                illegal;
    logic [NUM_REGS-1:0] reg_in;
    logic [NUM_REGS-1:0] reg_out;
    logic                pc_out;
    logic                pc_in;
    logic                inc_pc;
    logic                mar_in;
    logic                mdr_in;
    logic                mdr_out;
    logic                read;
    logic                ir_in;
    logic                y_in;
    logic                z_in;
    logic                zlow_out;
    logic                zhigh_out;
    logic                hi_in;
    logic                lo_in;
    logic [12:0]         alu_sel;
  } out_t;

  state_t               state_q, state_d;
  cls_t                 cls_q, cls_d, dec_cls;
  logic [12:0]          alu_q, alu_d, dec_alu;
  logic [REG_SEL_W-1:0] ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [REG_SEL_W-1:0] ir_ra, ir_rb, ir_rc;
  logic [3:0]           wait_q, wait_d;
  logic [4:0]           op;
  out_t                 out_q, out_d, out_v;
  logic                 adv;
  logic                 ir_unused;

  assign op        = bus.ir[31:27];
  assign ir_ra     = bus.ir[26 -: REG_SEL_W];
  assign ir_rb     = bus.ir[26-REG_SEL_W -: REG_SEL_W];
  assign ir_rc     = bus.ir[26-2*REG_SEL_W -: REG_SEL_W];
  assign ir_unused = ^bus.ir[26-3*REG_SEL_W:0];

`ifdef SEQ_SINGLE_STEP_EN
  assign adv = step_en || state_q == S_IDLE
            || state_q == S_DONE;
`else
  assign adv = 1'b1;
`endif

  function automatic logic [NUM_REGS-1:0] oh(
    input logic [REG_SEL_W-1:0] r
  );
    return NUM_REGS'(1) << r;
  endfunction

  always_comb begin
    dec_cls = C_ILL;
    dec_alu = '0;
    case (op)
      5'b00011: begin dec_cls = C_BIN; dec_alu[2]  = 1'b1; end
      5'b00100: begin dec_cls = C_BIN; dec_alu[3]  = 1'b1; end
      5'b00101: begin dec_cls = C_BIN; dec_alu[0]  = 1'b1; end
      5'b00110: begin dec_cls = C_BIN; dec_alu[1]  = 1'b1; end
      5'b00111: begin dec_cls = C_BIN; dec_alu[6]  = 1'b1; end
      5'b01000: begin dec_cls = C_BIN; dec_alu[7]  = 1'b1; end
      5'b01001: begin dec_cls = C_BIN; dec_alu[8]  = 1'b1; end
      5'b01010: begin dec_cls = C_BIN; dec_alu[9]  = 1'b1; end
      5'b01011: begin dec_cls = C_BIN; dec_alu[10] = 1'b1; end
      5'b01111: begin dec_cls = C_TWO; dec_alu[4]  = 1'b1; end
      5'b10000: begin dec_cls = C_TWO; dec_alu[5]  = 1'b1; end
      5'b10001: begin dec_cls = C_UN;  dec_alu[11] = 1'b1; end
      5'b10010: begin dec_cls = C_UN;  dec_alu[12] = 1'b1; end
      default:  dec_cls = C_ILL;
    endcase
    // fields naming a register that doesn't exist make the op illegal
    if (int'(ir_ra) >= NUM_REGS || int'(ir_rb) >= NUM_REGS
        || (dec_cls == C_BIN && int'(ir_rc) >= NUM_REGS))
      dec_cls = C_ILL;
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    cls_d   = cls_q;
    alu_d   = alu_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    if (adv) begin
      case (state_q)
        S_IDLE: if (bus.start) state_d = S_T0;
        S_T0: begin
          state_d = S_T1;
          wait_d  = 4'(MEM_WAIT);
        end
        S_T1: begin
          if (wait_q == '0) state_d = S_T2;
          else              wait_d  = wait_q - 4'd1;
        end
        S_T2: begin
          state_d = S_T3;
          cls_d   = dec_cls;
          alu_d   = dec_alu;
          ra_d    = ir_ra;
          rb_d    = ir_rb;
          rc_d    = ir_rc;
        end
        S_T3: begin
          case (cls_q)
            C_UN:    state_d = S_T5;
            C_ILL:   state_d = S_DONE;
            default: state_d = S_T4;
          endcase
        end
        S_T4:   state_d = S_T5;
        S_T5:   state_d = (cls_q == C_TWO) ? S_T6 : S_DONE;
        S_T6:   state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // outputs are decoded from the next state so they register with it
  always_comb begin
    out_d = '0;
    if (!adv) begin
      out_d = out_q;
    end else begin
      out_d.busy = state_d != S_IDLE && state_d != S_DONE;
      case (state_d)
        S_T0: begin
          out_d.pc_out = 1'b1;
          out_d.mar_in = 1'b1;
          out_d.inc_pc = 1'b1;
          out_d.z_in   = 1'b1;
        end
        S_T1: begin
          out_d.zlow_out = 1'b1;
          out_d.read     = 1'b1;
          out_d.mdr_in   = 1'b1;
          out_d.pc_in    = state_q != S_T1;
        end
        S_T2: begin
          out_d.mdr_out = 1'b1;
          out_d.ir_in   = 1'b1;
        end
        S_T3: begin
          case (cls_d)
            C_BIN: begin
              out_d.reg_out = oh(rb_d);
              out_d.y_in    = 1'b1;
            end
            C_TWO: begin
              out_d.reg_out = oh(ra_d);
              out_d.y_in    = 1'b1;
            end
            C_UN: begin
              out_d.reg_out = oh(rb_d);
              out_d.alu_sel = alu_d;
              out_d.z_in    = 1'b1;
            end
            default: ;
          endcase
        end
        S_T4: begin
          out_d.reg_out = oh(cls_d == C_TWO ? rb_d : rc_d);
          out_d.alu_sel = alu_d;
          out_d.z_in    = 1'b1;
        end
        S_T5: begin
          out_d.zlow_out = 1'b1;
          if (cls_d == C_TWO)
            out_d.lo_in = 1'b1;
          else if (!(R0_WRITE_INHIBIT != 0 && ra_d == '0))
            out_d.reg_in = oh(ra_d);
        end
        S_T6: begin
          out_d.zhigh_out = 1'b1;
          out_d.hi_in     = 1'b1;
        end
        S_DONE: begin
          out_d.done    = 1'b1;
          out_d.illegal = cls_d == C_ILL;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_v = out_q;
`ifdef SEQ_SINGLE_STEP_EN
    if (!adv) begin
      out_v      = '0;
      out_v.busy = out_q.busy;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cls_q   <= C_ILL;
      alu_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy      = out_v.busy;
  assign bus.done      = out_v.done;
  assign bus.illegal   = out_v.illegal;
  assign bus.reg_in    = out_v.reg_in;
  assign bus.reg_out   = out_v.reg_out;
  assign bus.pc_out    = out_v.pc_out;
  assign bus.pc_in     = out_v.pc_in;
  assign bus.inc_pc    = out_v.inc_pc;
  assign bus.mar_in    = out_v.mar_in;
  assign bus.mdr_in    = out_v.mdr_in;
  assign bus.mdr_out   = out_v.mdr_out;
  assign bus.read      = out_v.read;
  assign bus.ir_in     = out_v.ir_in;
  assign bus.y_in      = out_v.y_in;
  assign bus.z_in      = out_v.z_in;
  assign bus.zlow_out  = out_v.zlow_out;
  assign bus.zhigh_out = out_v.zhigh_out;
  assign bus.hi_in     = out_v.hi_in;
  assign bus.lo_in     = out_v.lo_in;
  assign bus.alu_sel   = out_v.alu_sel;

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: scoreboard bench, dut_a (W=0, R0 inhibit)
// and dut_b (W=2); expected per-cycle strobe traces are queued per DUT.
module tb_alu_instr_sequencer;
  localparam int NR = 16;

  localparam logic [13:0] PCOUT  = 14'h2000;
  localparam logic [13:0] PCIN   = 14'h1000;
  localparam logic [13:0] INCPC  = 14'h0800;
  localparam logic [13:0] MARIN  = 14'h0400;
  localparam logic [13:0] MDRIN  = 14'h0200;
  localparam logic [13:0] MDROUT = 14'h0100;
  localparam logic [13:0] READ   = 14'h0080;
  localparam logic [13:0] IRIN   = 14'h0040;
  localparam logic [13:0] YIN    = 14'h0020;
  localparam logic [13:0] ZIN    = 14'h0010;
  localparam logic [13:0] ZLOW   = 14'h0008;
  localparam logic [13:0] ZHIGH  = 14'h0004;
  localparam logic [13:0] HIIN   = 14'h0002;
  localparam logic [13:0] LOIN   = 14'h0001;

  localparam int BIN = 0, TWO = 1, UN = 2, ILL = 3;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          illegal;
    logic [NR-1:0] ri;
    logic [NR-1:0] ro;
    logic [13:0]   s;
    logic [12:0]   al;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
`ifdef SEQ_SINGLE_STEP_EN
  logic step_en;
  logic step_mode;
  int   phase;
`endif

  alu_seq_if #(.NUM_REGS(NR)) ifa ();
  alu_seq_if #(.NUM_REGS(NR)) ifb ();

  alu_instr_sequencer #(
    .NUM_REGS(NR), .REG_SEL_W(4),
    .MEM_WAIT(0), .R0_WRITE_INHIBIT(1)
  ) dut_a (
    .clk(clk), .reset(rst_a),
`ifdef SEQ_SINGLE_STEP_EN
    .step_en(step_en),
`endif
    .bus(ifa)
  );

  alu_instr_sequencer #(
    .NUM_REGS(NR), .REG_SEL_W(4),
    .MEM_WAIT(2), .R0_WRITE_INHIBIT(0)
  ) dut_b (
    .clk(clk), .reset(rst_b),
`ifdef SEQ_SINGLE_STEP_EN
    .step_en(step_en),
`endif
    .bus(ifb)
  );

  vec_t cur_a, cur_b;
  assign cur_a = {ifa.busy, ifa.done, ifa.illegal,
    ifa.reg_in, ifa.reg_out, ifa.pc_out, ifa.pc_in,
    ifa.inc_pc, ifa.mar_in, ifa.mdr_in, ifa.mdr_out,
    ifa.read, ifa.ir_in, ifa.y_in, ifa.z_in,
    ifa.zlow_out, ifa.zhigh_out, ifa.hi_in, ifa.lo_in,
    ifa.alu_sel};
  assign cur_b = {ifb.busy, ifb.done, ifb.illegal,
    ifb.reg_in, ifb.reg_out, ifb.pc_out, ifb.pc_in,
    ifb.inc_pc, ifb.mar_in, ifb.mdr_in, ifb.mdr_out,
    ifb.read, ifb.ir_in, ifb.y_in, ifb.z_in,
    ifb.zlow_out, ifb.zhigh_out, ifb.hi_in, ifb.lo_in,
    ifb.alu_sel};

  vec_t qa[$];
  vec_t qb[$];
  int   la[$];
  int   lb[$];
  int   total = 0;
  int   bad = 0;
  int   cnt_a = 0;
  int   cnt_b = 0;
  int   mode_a = 0;
  int   mode_b = 0;
  bit   final_chk = 1'b0;
  bit   final_done = 1'b0;

  function automatic logic [NR-1:0] oh(input int r);
    logic [NR-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic vec_t st(input logic [13:0] s,
    input logic [NR-1:0] ri, input logic [NR-1:0] ro,
    input logic [12:0] al);
    vec_t v;
    v = '0;
    v.busy = 1'b1;
    v.s = s;
    v.ri = ri;
    v.ro = ro;
    v.al = al;
    return v;
  endfunction

  function automatic logic [31:0] mkir(input logic [4:0] op,
    input int ra, input int rb, input int rc);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'd0};
  endfunction

  task automatic push(input bit to_b, input int cls,
    input int ra, input int rb, input int rc,
    input int alu, input int w, input bit inh, input int lat);
    vec_t t[$];
    vec_t d;
    logic [12:0] al;
    logic [NR-1:0] wr;
    al = 13'(1) << alu;
    wr = (inh && ra == 0) ? '0 : oh(ra);
    t.push_back(st(PCOUT | MARIN | INCPC | ZIN, '0, '0, '0));
    t.push_back(st(ZLOW | PCIN | READ | MDRIN, '0, '0, '0));
    for (int i = 0; i < w; i++)
      t.push_back(st(ZLOW | READ | MDRIN, '0, '0, '0));
    t.push_back(st(MDROUT | IRIN, '0, '0, '0));
    case (cls)
      BIN: begin
        t.push_back(st(YIN, '0, oh(rb), '0));
        t.push_back(st(ZIN, '0, oh(rc), al));
        t.push_back(st(ZLOW, wr, '0, '0));
      end
      TWO: begin
        t.push_back(st(YIN, '0, oh(ra), '0));
        t.push_back(st(ZIN, '0, oh(rb), al));
        t.push_back(st(ZLOW | LOIN, '0, '0, '0));
        t.push_back(st(ZHIGH | HIIN, '0, '0, '0));
      end
      UN: begin
        t.push_back(st(ZIN, '0, oh(rb), al));
        t.push_back(st(ZLOW, wr, '0, '0));
      end
      default: t.push_back(st('0, '0, '0, '0));
    endcase
    d = '0;
    d.done = 1'b1;
    d.illegal = (cls == ILL);
    t.push_back(d);
    foreach (t[i]) begin
      if (to_b) qb.push_back(t[i]);
      else      qa.push_back(t[i]);
    end
    if (to_b) lb.push_back(lat);
    else      la.push_back(lat);
  endtask

  task automatic chk(input string nm, input vec_t act,
    input vec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h",
        nm, $time, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act,
    input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0d exp=%0d",
        nm, $time, act, exp);
    end
  endtask

  task automatic mon(input bit b, input vec_t cur,
    input int mode, input bit stall);
    vec_t e;
    int n;
    if (mode == 2) return;
    if (mode == 1) begin
      chk(b ? "rst_b" : "rst_a", cur, '0);
      return;
    end
    if (stall) begin
      e = '0;
      e.busy = 1'b1;
      chk(b ? "stall_b" : "stall_a", cur, e);
      return;
    end
    if (!cur.busy && !cur.done) begin
      chk(b ? "idle_b" : "idle_a", cur, '0);
      return;
    end
    if ((b ? qb.size() : qa.size()) == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s t=%0t act=%h exp=idle",
        b ? "b" : "a", $time, cur);
    end else begin
      e = b ? qb.pop_front() : qa.pop_front();
      chk(b ? "seq_b" : "seq_a", cur, e);
    end
    if (b) cnt_b++;
    else   cnt_a++;
    if (cur.done) begin
      n = b ? cnt_b : cnt_a;
      if ((b ? lb.size() : la.size()) == 0)
        chk_i(b ? "lat_b" : "lat_a", n, -1);
      else
        chk_i(b ? "lat_b" : "lat_a", n,
          b ? lb.pop_front() : la.pop_front());
      if (b) cnt_b = 0;
      else   cnt_a = 0;
    end
  endtask

  always @(negedge clk) begin
    bit sa, sb;
    sa = 1'b0;
    sb = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    sa = cur_a.busy && !step_en;
    sb = cur_b.busy && !step_en;
`endif
    mon(1'b0, cur_a, mode_a, sa);
    mon(1'b1, cur_b, mode_b, sb);
    if (final_chk && !final_done) begin
      final_done = 1'b1;
      chk_i("qa_left", qa.size(), 0);
      chk_i("qb_left", qb.size(), 0);
    end
  end

`ifdef SEQ_SINGLE_STEP_EN
  initial begin
    step_en = 1'b1;
    phase = 0;
    forever begin
      @(posedge clk);
      #1;
      if (step_mode) begin
        phase = (phase + 1) % 3;
        step_en = (phase == 0);
      end else begin
        phase = 0;
        step_en = 1'b1;
      end
    end
  end
`endif

  task automatic issue(input bit b, input logic [31:0] ir,
    input int hold);
    if (b) begin
      ifb.ir = ir;
      ifb.start = 1'b1;
    end else begin
      ifa.ir = ir;
      ifa.start = 1'b1;
    end
    repeat (hold) @(posedge clk);
    #1;
    if (b) ifb.start = 1'b0;
    else   ifa.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 150 && (qa.size() != 0
         || qb.size() != 0); i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b0;
`endif
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifa.ir = '0;
    ifb.ir = '0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    mode_a = 1;
    mode_b = 1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    mode_a = 0;
    mode_b = 0;
    repeat (2) @(posedge clk);
    #1;

    push(0, UN, 5, 0, 0, 12, 0, 1, 6);
    issue(0, 32'h92800000, 1);
    drain();
    push(0, BIN, 3, 4, 4, 2, 0, 1, 7);
    issue(0, 32'h19A20000, 1);
    drain();
    push(0, BIN, 0, 0, 0, 2, 0, 1, 7);
    issue(0, 32'h18000000, 1);
    drain();
    push(0, BIN, 1, 2, 3, 3, 0, 1, 7);
    issue(0, mkir(5'b00100, 1, 2, 3), 1);
    drain();
    push(0, BIN, 15, 14, 13, 10, 0, 1, 7);
    issue(0, mkir(5'b01011, 15, 14, 13), 1);
    drain();
    push(0, UN, 7, 9, 0, 11, 0, 1, 6);
    issue(0, mkir(5'b10001, 7, 9, 0), 1);
    drain();

    push(0, ILL, 0, 0, 0, 0, 0, 1, 5);
    issue(0, mkir(5'b11111, 0, 0, 0), 1);
    drain();
    push(0, BIN, 3, 4, 4, 2, 0, 1, 7);
    issue(0, 32'h19A20000, 1);
    drain();

    // start held through DONE relaunches once
    push(0, BIN, 2, 3, 4, 1, 0, 1, 7);
    push(0, BIN, 2, 3, 4, 1, 0, 1, 7);
    issue(0, mkir(5'b00110, 2, 3, 4), 9);
    drain();

    push(1, TWO, 2, 0, 0, 4, 2, 0, 10);
    issue(1, 32'h79000000, 1);
    drain();
    push(1, TWO, 6, 1, 0, 5, 2, 0, 10);
    issue(1, mkir(5'b10000, 6, 1, 0), 1);
    drain();
    push(1, ILL, 0, 0, 0, 0, 2, 0, 7);
    issue(1, mkir(5'b00000, 0, 0, 0), 1);
    drain();
    push(1, BIN, 0, 5, 9, 2, 2, 0, 9);
    issue(1, mkir(5'b00011, 0, 5, 9), 1);
    drain();

    mode_a = 2;
    issue(0, 32'h19A20000, 1);
    repeat (4) @(posedge clk);
    #1;
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    mode_a = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(posedge clk);
    #1;
    mode_a = 0;
    push(0, BIN, 3, 4, 4, 2, 0, 1, 7);
    issue(0, 32'h19A20000, 1);
    drain();

`ifdef SEQ_SINGLE_STEP_EN
    step_mode = 1'b1;
    push(0, BIN, 0, 0, 0, 2, 0, 1, 7);
    issue(0, 32'h18000000, 1);
    drain();
    step_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`endif

    final_chk = 1'b1;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
